// File: rtl/radiometer_sequencer.sv
// Purpose : Dicke-switched radiometer front-end sequencer. Averages N_AVG ADC samples
//           per switch phase after a settle window and ships a 4-word frame over a UART.
// Latency : one clk from switch_pwm edge to state change; frame starts 1 clk after the
//           last ground sample.
// Backpres: each word is issued only while tx_busy=0, and the next word waits for a full
//           busy high/low handshake. enable=0 is deferred until the frame is complete.
//
// Ports:
//   clk          - 100 MHz system clock
//   reset        - asynchronous active-low reset
//   enable       - run request
//   switch_pwm   - switch phase, 1 = signal feed, 0 = ground feed
//   sample_valid - single-cycle strobe qualifying sample
//   sample       - 12-bit unsigned ADC result
//   tx_busy      - UART transmitter busy
//   tx_start     - single-cycle word-send strobe
//   tx_data      - word being sent, held until the next tx_start
//   frame_done   - single-cycle pulse once the last word of a frame has been accepted
//   err          - sticky short-phase error flag
//   state        - current FSM state, for debug LEDs
module radiometer_sequencer #(
    parameter int N_AVG  = 16,
    parameter int SETTLE = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        switch_pwm,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [11:0] tx_data,
    output logic        frame_done,
    output logic        err,
    output logic [2:0]  state
);

    localparam int LOG2N = $clog2(N_AVG);
    localparam int ACC_W = 12 + LOG2N;
    localparam int CNT_W = $clog2(N_AVG + 1);

    localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(N_AVG - 1);
    localparam logic [11:0]      SYNC_WORD   = 12'hA5A;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_RISE  = 3'd1,
        SETTLE_SIG = 3'd2,
        ACC_SIG    = 3'd3,
        WAIT_FALL  = 3'd4,
        SETTLE_GND = 3'd5,
        ACC_GND    = 3'd6,
        SEND       = 3'd7
    } state_t;

    // Per-word UART handshake inside SEND.
    typedef enum logic [1:0] {
        TX_ISSUE   = 2'd0,
        TX_WAIT_HI = 2'd1,
        TX_WAIT_LO = 2'd2
    } tx_phase_t;

    state_t            st;
    tx_phase_t         tx_ph;
    logic [1:0]        word_idx;
    logic              pwm_q;
    logic              en_q;
    logic [15:0]       settle_cnt;
    logic [CNT_W-1:0]  smp_cnt;
    logic [ACC_W-1:0]  acc_sig;
    logic [ACC_W-1:0]  acc_gnd;

    logic              pwm_rise;
    logic              pwm_fall;
    logic              pwm_chg;
    logic              in_window;
    logic [11:0]       avg_sig;
    logic [11:0]       avg_gnd;
    logic [11:0]       diff;
    logic [11:0]       word_mux;

    assign state = st;

    // Edges are taken against the registered previous level, so a level that is
    // already high when WAIT_RISE is entered does not start an acquisition.
    assign pwm_rise = switch_pwm & ~pwm_q;
    assign pwm_fall = ~switch_pwm & pwm_q;
    assign pwm_chg  = switch_pwm ^ pwm_q;

    // A level change in any of these states means the phase was too short.
    assign in_window = (st == SETTLE_SIG) || (st == ACC_SIG) ||
                       (st == SETTLE_GND) || (st == ACC_GND);

    // Averages are the truncated top 12 bits; the accumulators are sized so
    // N_AVG full-scale samples cannot overflow.
    assign avg_sig = acc_sig[ACC_W-1:LOG2N];
    assign avg_gnd = acc_gnd[ACC_W-1:LOG2N];
    assign diff    = (avg_sig >= avg_gnd) ? (avg_sig - avg_gnd) : 12'h000;

    always_comb begin
        word_mux = SYNC_WORD;
        case (word_idx)
            2'd0:    word_mux = SYNC_WORD;
            2'd1:    word_mux = avg_sig;
            2'd2:    word_mux = avg_gnd;
            default: word_mux = diff;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st         <= IDLE;
            tx_ph      <= TX_ISSUE;
            word_idx   <= 2'd0;
            pwm_q      <= 1'b0;
            en_q       <= 1'b0;
            settle_cnt <= '0;
            smp_cnt    <= '0;
            acc_sig    <= '0;
            acc_gnd    <= '0;
            tx_start   <= 1'b0;
            tx_data    <= 12'h000;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            pwm_q      <= switch_pwm;
            en_q       <= enable;
            tx_start   <= 1'b0;
            frame_done <= 1'b0;

            if (st == IDLE) begin
                acc_sig    <= '0;
                acc_gnd    <= '0;
                smp_cnt    <= '0;
                settle_cnt <= '0;
                word_idx   <= 2'd0;
                tx_ph      <= TX_ISSUE;
                if (enable) begin
                    // Only a fresh run request clears the sticky error.
                    if (!en_q) begin
                        err <= 1'b0;
                    end
                    st <= WAIT_RISE;
                end
            end else if (st != SEND && !enable) begin
                // Partial data is dropped; IDLE clears it on the next cycle.
                st <= IDLE;
            end else if (in_window && pwm_chg) begin
                // Short phase: any sample arriving this same cycle is discarded.
                err        <= 1'b1;
                acc_sig    <= '0;
                acc_gnd    <= '0;
                smp_cnt    <= '0;
                settle_cnt <= '0;
                st         <= WAIT_RISE;
            end else begin
                case (st)
                    WAIT_RISE: begin
                        if (pwm_rise) begin
                            acc_sig    <= '0;
                            acc_gnd    <= '0;
                            smp_cnt    <= '0;
                            settle_cnt <= '0;
                            st         <= SETTLE_SIG;
                        end
                    end

                    SETTLE_SIG: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            settle_cnt <= '0;
                            smp_cnt    <= '0;
                            st         <= ACC_SIG;
                        end else begin
                            settle_cnt <= settle_cnt + 16'd1;
                        end
                    end

                    ACC_SIG: begin
                        if (sample_valid) begin
                            acc_sig <= acc_sig + ACC_W'(sample);
                            if (smp_cnt == CNT_LAST) begin
                                smp_cnt <= '0;
                                st      <= WAIT_FALL;
                            end else begin
                                smp_cnt <= smp_cnt + CNT_W'(1);
                            end
                        end
                    end

                    WAIT_FALL: begin
                        if (pwm_fall) begin
                            settle_cnt <= '0;
                            st         <= SETTLE_GND;
                        end
                    end

                    SETTLE_GND: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            settle_cnt <= '0;
                            smp_cnt    <= '0;
                            st         <= ACC_GND;
                        end else begin
                            settle_cnt <= settle_cnt + 16'd1;
                        end
                    end

                    ACC_GND: begin
                        if (sample_valid) begin
                            acc_gnd <= acc_gnd + ACC_W'(sample);
                            if (smp_cnt == CNT_LAST) begin
                                smp_cnt  <= '0;
                                word_idx <= 2'd0;
                                tx_ph    <= TX_ISSUE;
                                st       <= SEND;
                            end else begin
                                smp_cnt <= smp_cnt + CNT_W'(1);
                            end
                        end
                    end

                    SEND: begin
                        case (tx_ph)
                            TX_ISSUE: begin
                                if (!tx_busy) begin
                                    tx_start <= 1'b1;
                                    tx_data  <= word_mux;
                                    tx_ph    <= TX_WAIT_HI;
                                end
                            end
                            TX_WAIT_HI: begin
                                if (tx_busy) begin
                                    tx_ph <= TX_WAIT_LO;
                                end
                            end
                            TX_WAIT_LO: begin
                                if (!tx_busy) begin
                                    tx_ph <= TX_ISSUE;
                                    if (word_idx == 2'd3) begin
                                        frame_done <= 1'b1;
                                        word_idx   <= 2'd0;
                                        st         <= enable ? WAIT_RISE : IDLE;
                                    end else begin
                                        word_idx <= word_idx + 2'd1;
                                    end
                                end
                            end
                            default: tx_ph <= TX_ISSUE;
                        endcase
                    end

                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/radiometer_sequencer.md
RADIOMETER_SEQUENCER -- requirements
Module: radiometer_sequencer

Interface
REQ-001 The block SHALL have parameter N_AVG, default 16: samples averaged per phase; power of two, 2..256.
REQ-002 The block SHALL have parameter SETTLE, default 64: clk cycles ignored after each switch_pwm edge; value 1..65535.
REQ-003 The block SHALL have port clk, input, 1 bit: 100 MHz system clock; the only clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: run request, synchronous to clk.
REQ-006 The block SHALL have port switch_pwm, input, 1 bit: switching phase; 1 = signal feed, 0 = ground feed; synchronous to clk.
REQ-007 The block SHALL have port sample_valid, input, 1 bit: single-cycle strobe qualifying sample.
REQ-008 The block SHALL have port sample, input, 12 bits: unsigned ADC result.
REQ-009 The block SHALL have port tx_busy, input, 1 bit: UART transmitter busy.
REQ-010 The block SHALL have port tx_start, output, 1 bit: single-cycle word-send strobe.
REQ-011 The block SHALL have port tx_data, output, 12 bits: word to transmit; valid while tx_start is high and held until the next tx_start.
REQ-012 The block SHALL have port frame_done, output, 1 bit: single-cycle pulse after the last word of a frame is accepted.
REQ-013 The block SHALL have port err, output, 1 bit: sticky short-phase error flag.
REQ-014 The block SHALL have port state, output, 3 bits: current FSM state encoding, for LED debug.

Function
REQ-015 The FSM SHALL use states IDLE=0, WAIT_RISE=1, SETTLE_SIG=2, ACC_SIG=3, WAIT_FALL=4, SETTLE_GND=5, ACC_GND=6, SEND=7.
REQ-016 IDLE SHALL go to WAIT_RISE when enable=1; while in IDLE, both accumulators and the sample counters SHALL be cleared.
REQ-017 WAIT_RISE SHALL go to SETTLE_SIG on the first cycle where switch_pwm=1 and its registered previous value is 0; a level of 1 alone SHALL NOT trigger the transition.
REQ-018 SETTLE_SIG and SETTLE_GND SHALL count exactly SETTLE cycles and then advance; sample_valid SHALL be ignored during settle.
REQ-019 ACC_SIG SHALL add sample to the signal accumulator on each sample_valid, up to N_AVG samples, and SHALL go to WAIT_FALL when the count reaches N_AVG.
REQ-020 WAIT_FALL SHALL go to SETTLE_GND on a falling edge of switch_pwm.
REQ-021 ACC_GND SHALL mirror ACC_SIG for the ground accumulator and SHALL go to SEND when the count reaches N_AVG.
REQ-022 Each accumulator SHALL be 12+log2(N_AVG) bits wide; the average SHALL be the accumulator shifted right by log2(N_AVG) (truncating), giving 12 bits.
REQ-023 If switch_pwm changes level during SETTLE_* or ACC_* before N_AVG samples are collected, the block SHALL set err, clear both accumulators, and go to WAIT_RISE.
REQ-024 A frame SHALL be 4 words in order: 12'hA5A, avg_sig, avg_gnd, diff; diff = avg_sig - avg_gnd when avg_sig >= avg_gnd, else 0.
REQ-025 In SEND, tx_start SHALL pulse for 1 cycle only when tx_busy=0; the block SHALL then wait for tx_busy=1 followed by tx_busy=0 before sending the next word.
REQ-026 After word 3 completes, the block SHALL pulse frame_done for 1 cycle and go to WAIT_RISE if enable=1, else to IDLE.
REQ-027 If enable=0 in any state except SEND, the FSM SHALL go to IDLE on the next cycle and discard partial data; in SEND, the frame SHALL complete first.
REQ-028 A sample_valid arriving in the same cycle as a switch_pwm level change during ACC_* SHALL be discarded, and the error path of REQ-023 SHALL apply.
REQ-029 err SHALL clear only on reset or on an enable rising edge seen in IDLE.

Reset
REQ-030 While reset=0, asynchronously: state=IDLE, tx_start=0, tx_data=0, frame_done=0, err=0, all accumulators, counters and the edge register=0.
REQ-031 After reset deasserts, the block SHALL stay in IDLE until enable=1.

Verification
REQ-032 N_AVG=4, SETTLE=8, enable=1, pwm square wave with 64-cycle half-periods, samples 100 in high phase and 40 in low phase, every 2 cycles, tx_busy held high 10 cycles after each start -> words A5A, 064, 028, 03C, then frame_done.
REQ-033 Same setup with ground samples 200 -> diff word = 000.
REQ-034 pwm high phase of 12 cycles (only 2 samples after settle) -> err=1, no tx_start, state returns to 1; next full period produces a valid frame.
REQ-035 enable dropped during ACC_GND -> state=0 the next cycle, no tx_start; enable dropped during SEND word 1 -> all 4 words sent, then state=0.
REQ-036 reset asserted mid-SEND while tx_busy=1 -> all outputs 0 immediately; after release, no further tx_start until a new full acquisition completes.
REQ-037 Samples 4095 x4 in both phases -> avg_sig=FFF, avg_gnd=FFF, diff=000, with no accumulator overflow.
